// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - opcode, shift-type and FSM state definitions for shift_sequencer
package shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam logic [1:0] ST_LL = 2'b00;
    localparam logic [1:0] ST_LR = 2'b10;
    localparam logic [1:0] ST_AR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command and result handshake bundle for shift_sequencer
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shifter_32.sv
// rtl/shifter_32.sv - combinational 32-bit shifter: logical left, logical right, arithmetic right
import shift_pkg::*;

module shifter_32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    input  logic [1:0]  stype,
    output logic [31:0] result
);
    always_comb begin
        case (stype)
            ST_LR:   result = data >> amt;
            ST_AR:   result = $unsigned($signed(data) >>> amt);
            default: result = data << amt;
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - issue/retire FSM around one shared shifter_32; rotates take two passes
import shift_pkg::*;

module shift_sequencer #(
    parameter bit ROT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus,
    output logic              busy
);
    state_e      state, state_nxt;
    logic [31:0] op_data;
    logic [4:0]  op_amt;
    logic [2:0]  op_op;
    logic [31:0] partial;
    logic [31:0] out_data_q;
    logic        out_err_q;

    logic        is_rot, legal, accept, two_pass;
    logic [5:0]  amt_comp;
    logic [4:0]  sh_amt;
    logic [1:0]  sh_type;
    logic [31:0] sh_out;

    assign is_rot   = ROT_EN && (op_op == OP_ROL || op_op == OP_ROR);
    assign legal    = (op_op == OP_SLL) || (op_op == OP_SRL) || (op_op == OP_SRA) || is_rot;
    assign two_pass = is_rot && (op_amt != 5'd0);
    assign amt_comp = 6'd32 - {1'b0, op_amt};

    assign bus.in_ready  = (state == S_IDLE) || (state == S_OUT && bus.out_ready);
    assign bus.out_valid = (state == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign busy          = (state != S_IDLE);
    assign accept        = bus.in_valid && bus.in_ready;

    // Second pass recovers the bits the first pass shifted out, from the opposite side
    always_comb begin
        sh_amt  = op_amt;
        sh_type = ST_LL;
        if (state == S_P2) begin
            sh_amt  = amt_comp[4:0];
            sh_type = (op_op == OP_ROL) ? ST_LR : ST_LL;
        end else begin
            case (op_op)
                OP_SRL, OP_ROR: sh_type = ST_LR;
                OP_SRA:         sh_type = ST_AR;
                default:        sh_type = ST_LL;
            endcase
        end
    end

    shifter_32 u_shifter (
        .data   (op_data),
        .amt    (sh_amt),
        .stype  (sh_type),
        .result (sh_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_P1;
            S_P1:   state_nxt = (legal && two_pass) ? S_P2 : S_OUT;
            S_P2:   state_nxt = S_OUT;
            S_OUT:  if (bus.out_ready) state_nxt = accept ? S_P1 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_data    <= '0;
            op_amt     <= '0;
            op_op      <= '0;
            partial    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_data <= bus.in_data;
                op_amt  <= bus.in_amt;
                op_op   <= bus.in_op;
            end
            if (state == S_P1) begin
                if (!legal) begin
                    out_data_q <= op_data;
                    out_err_q  <= 1'b1;
                end else if (two_pass) begin
                    partial <= sh_out;
                end else begin
                    out_data_q <= sh_out;
                    out_err_q  <= 1'b0;
                end
            end else if (state == S_P2) begin
                out_data_q <= partial | sh_out;
                out_err_q  <= 1'b0;
            end
        end
    end
endmodule
